// File: rtl/ncl_addsub_seq_pkg.sv
// Shared dual-rail (NCL) definitions for the sequential add/subtract block:
// digit codes, mode encodings, controller states and the DATA predicate.
package ncl_pkg;

  localparam logic [1:0] NCL_NULL    = 2'b00;
  localparam logic [1:0] NCL_DATA0   = 2'b01;
  localparam logic [1:0] NCL_DATA1   = 2'b10;
  localparam logic [1:0] NCL_ILLEGAL = 2'b11;

  localparam logic [1:0] OP_ADD = NCL_DATA0;
  localparam logic [1:0] OP_SUB = NCL_DATA1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_data(input logic [1:0] d);
    return (d == NCL_DATA0) || (d == NCL_DATA1);
  endfunction

endpackage

// File: rtl/ncl_addsub_seq_if.sv
// Operand/result bus of ncl_addsub_seq: dual-rail data plus the two
// valid/ready handshakes and the rejection pulse.
interface ncl_addsub_seq_if #(
  parameter int WIDTH = 8
);
  logic [2*WIDTH-1:0] A;
  logic [2*WIDTH-1:0] B;
  logic [1:0]         Cin;
  logic [1:0]         Op;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] S;
  logic [1:0]         Cout;
  logic [1:0]         Overflow;
  logic               out_valid;
  logic               out_ready;
  logic               err;

  modport slave (
    input  A, B, Cin, Op, in_valid, out_ready,
    output in_ready, S, Cout, Overflow, out_valid, err
  );

  modport master (
    output A, B, Cin, Op, in_valid, out_ready,
    input  in_ready, S, Cout, Overflow, out_valid, err
  );
endinterface

// File: rtl/ncl_addsub_seq_digit_add.sv
// Combinational dual-rail full adder for one digit; any non-DATA input
// keeps both outputs NULL.
module ncl_digit_add
  import ncl_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] cin,
  output logic [1:0] s,
  output logic [1:0] cout
);
  logic w_valid;
  logic w_sum;
  logic w_maj;

  assign w_valid = is_data(a) && is_data(b) && is_data(cin);
  assign w_sum   = a[1] ^ b[1] ^ cin[1];
  assign w_maj   = (a[1] & b[1]) | (a[1] & cin[1]) | (b[1] & cin[1]);

  assign s    = w_valid ? {w_sum, ~w_sum} : NCL_NULL;
  assign cout = w_valid ? {w_maj, ~w_maj} : NCL_NULL;
endmodule

// File: rtl/ncl_addsub_seq.sv
// Sequential dual-rail adder/subtractor: DPC digits per clock, LSB first.
//   state | meaning
//   IDLE  | ready for operands; illegal operand sets pulse err
//   CALC  | resolving DPC digits per cycle, carry held in r_carry
//   DONE  | result presented until out_ready
module ncl_addsub_seq
  import ncl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DPC   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ncl_addsub_seq_if.slave bus
);
  localparam int NGRP = WIDTH / DPC;
  localparam int IDXW = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int GW   = 2 * DPC;

  if ((WIDTH % DPC) != 0) begin : g_bad_dpc
    $error("ncl_addsub_seq: WIDTH must be a multiple of DPC");
  end

  state_t              r_state, w_next;
  logic [2*WIDTH-1:0]  r_a, r_b, r_s, w_b_inv, w_s_next;
  logic [1:0]          r_carry, r_cout, r_ovf;
  logic [IDXW-1:0]     r_idx;
  logic                r_err;
  logic [WIDTH-1:0]    w_a_ok, w_b_ok;
  logic                w_legal, w_accept, w_reject, w_last;
  logic [DPC:0][1:0]   w_c;
  logic [GW-1:0]       w_sgrp;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_digit_chk
    assign w_a_ok[gi] = is_data(bus.A[2*gi+1:2*gi]);
    assign w_b_ok[gi] = is_data(bus.B[2*gi+1:2*gi]);
    // Dual-rail inversion is just a rail swap.
    assign w_b_inv[2*gi+1:2*gi] = {bus.B[2*gi], bus.B[2*gi+1]};
  end

  assign w_legal  = (&w_a_ok) && (&w_b_ok) && is_data(bus.Cin) && is_data(bus.Op);
  assign w_accept = (r_state == ST_IDLE) && bus.in_valid && w_legal;
  assign w_reject = (r_state == ST_IDLE) && bus.in_valid && !w_legal;
  assign w_last   = (r_idx == IDXW'(NGRP - 1));

  assign w_c[0] = r_carry;
  for (genvar k = 0; k < DPC; k++) begin : g_add
    ncl_digit_add u_digit (
      .a    (r_a[2*k+1:2*k]),
      .b    (r_b[2*k+1:2*k]),
      .cin  (w_c[k]),
      .s    (w_sgrp[2*k+1:2*k]),
      .cout (w_c[k+1])
    );
  end

  // Result digits enter at the top and shift down, so after NGRP cycles
  // the first (LSB) group sits at the bottom.
  if (NGRP == 1) begin : g_s_one
    assign w_s_next = w_sgrp;
  end else begin : g_s_shift
    assign w_s_next = {w_sgrp, r_s[2*WIDTH-1:GW]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (w_accept) w_next = ST_CALC;
      end
      ST_CALC: if (w_last) w_next = ST_DONE;
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= NCL_NULL;
      r_cout  <= NCL_NULL;
      r_ovf   <= NCL_NULL;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_a     <= bus.A;
        r_b     <= (bus.Op == OP_SUB) ? w_b_inv : bus.B;
        r_carry <= bus.Cin;
        r_s     <= '0;
        r_idx   <= '0;
      end else if (r_state == ST_CALC) begin
        r_a     <= r_a >> GW;
        r_b     <= r_b >> GW;
        r_carry <= w_c[DPC];
        r_s     <= w_s_next;
        r_idx   <= w_last ? '0 : r_idx + IDXW'(1);
        if (w_last) begin
          r_cout <= w_c[DPC];
          r_ovf  <= (w_c[DPC-1][1] ^ w_c[DPC][1]) ? NCL_DATA1 : NCL_DATA0;
        end
      end
    end
  end

  assign bus.S        = (r_state == ST_DONE) ? r_s    : '0;
  assign bus.Cout     = (r_state == ST_DONE) ? r_cout : NCL_NULL;
  assign bus.Overflow = (r_state == ST_DONE) ? r_ovf  : NCL_NULL;
  assign bus.err      = r_err;
endmodule
